router_pkt_reader: RTL and testbench

Destination-side consumer for one router output FIFO. It drains the FIFO through the `empty`/`read_enb` interface and parses each packet: header byte (length in [7:2], destination in [1:0]), `length` payload bytes, then one parity byte. It forwards every byte to a downstream valid/ready sink with start/end markers and checks parity. It reports per-packet completion, parity errors and running counters, and sits between a router output port and the destination client logic.

---
 rtl/router_pkt_reader.sv | 226 ++++++++++++++++++++++
 tb/tb_router_pkt_reader.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_pkt_reader.sv
// router_pkt_reader
//   Drains one router output FIFO through the empty/read_enb interface.
//   Each packet is parsed as follows:
//     - a header byte (length in [7:2], destination in [1:0]),
//     - `length` payload bytes,
//     - one parity byte.
//   Every byte is forwarded unmodified to a valid/ready sink with sop/eop
//   markers. Parity is the XOR of the header and all payload bytes.
//
// Parameters
//   TIMEOUT_CYC : mid-packet starvation limit, in cycles (timeout build only)
//   CNT_W       : width of pkt_count
//
// Ports
//   clock, resetn          : clock (rising edge), asynchronous active-low reset
//   empty, fifo_data       : FIFO status and data (data valid the cycle after read_enb)
//   read_enb               : FIFO read strobe
//   m_data/m_valid/m_ready : sink handshake
//   m_sop/m_eop            : header / parity (or abort) markers
//   pkt_done, parity_err   : one-cycle completion and parity-error pulses
//   pkt_abort              : one-cycle timeout-abort pulse (0 when the feature is absent)
//   pkt_count              : completed packets (wraps)
//   err_count              : parity errors plus aborts (saturates at 255)
//   busy                   : packet in progress
//
// Optional feature
//   ROUTER_RD_TIMEOUT_EN enables the mid-packet starvation timeout.
module router_pkt_reader #(
  parameter int unsigned TIMEOUT_CYC = 30,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             empty,
  input  logic [7:0]       fifo_data,
  output logic             read_enb,
  output logic [7:0]       m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_sop,
  output logic             m_eop,
  output logic             pkt_done,
  output logic             parity_err,
  output logic             pkt_abort,
  output logic [CNT_W-1:0] pkt_count,
  output logic [7:0]       err_count,
  output logic             busy
);

  typedef enum logic [1:0] {ST_HDR, ST_PLD, ST_PAR} state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  // Buffer entry layout: {sop, eop, data}. Entry 0 is the head.
  logic [9:0]       r_buf [2];
  logic [9:0]       w_buf_nxt [2];
  logic [1:0]       r_occ;
  logic [1:0]       w_occ_nxt;
  logic             r_rd_pend;
  logic             r_run;
  logic [5:0]       r_remaining;
  logic [5:0]       w_remaining_nxt;
  logic [7:0]       r_acc;
  logic [7:0]       w_acc_nxt;
  logic             r_pkt_done;
  logic             r_parity_err;
  logic [CNT_W-1:0] r_pkt_count;
  logic [7:0]       r_err_count;

  logic             w_capture;
  logic             w_pop;
  logic             w_in_sop;
  logic             w_in_eop;
  logic             w_done;
  logic             w_perr;
  logic             w_timeout;

  assign w_capture = r_rd_pend;
  assign m_valid   = (r_occ != 2'd0);
  assign w_pop     = m_valid & m_ready;
  assign m_data    = r_buf[0][7:0];
  assign m_sop     = m_valid & r_buf[0][9];
  assign m_eop     = m_valid & r_buf[0][8];
  assign busy      = (r_state != ST_HDR);

  // r_run holds read_enb low while reset is asserted, even if the FIFO has data.
  assign read_enb  = r_run && !empty && ((r_occ + {1'b0, r_rd_pend}) < 2'd2);

  assign pkt_done   = r_pkt_done;
  assign parity_err = r_parity_err;
  assign pkt_count  = r_pkt_count;
  assign err_count  = r_err_count;

`ifdef ROUTER_RD_TIMEOUT_EN
  localparam int unsigned STV_W = $clog2(TIMEOUT_CYC + 1);

  logic [STV_W-1:0] r_starve;
  logic             w_starved;

  assign w_starved = busy && empty && !r_rd_pend;
  // The abort pulse coincides with the TIMEOUT_CYC-th starved cycle.
  assign w_timeout = w_starved && (r_starve == STV_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_starve <= '0;
    end else if (!busy || r_rd_pend || w_timeout) begin
      r_starve <= '0;
    end else if (empty) begin
      r_starve <= r_starve + 1'b1;
    end
  end
`else
  // No starvation counter: the packet waits indefinitely for more bytes.
  assign w_timeout = (TIMEOUT_CYC == 0) & 1'b0;
`endif

  assign pkt_abort = w_timeout;

  // Parse FSM: state register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_HDR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Parse FSM: next state and per-byte tags
  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_acc_nxt       = r_acc;
    w_in_sop        = 1'b0;
    w_in_eop        = 1'b0;
    w_done          = 1'b0;
    w_perr          = 1'b0;
    if (w_capture) begin
      case (r_state)
        ST_HDR: begin
          w_in_sop        = 1'b1;
          w_acc_nxt       = fifo_data;
          w_remaining_nxt = fifo_data[7:2];
          w_state_nxt     = (fifo_data[7:2] == 6'd0) ? ST_PAR : ST_PLD;
        end
        ST_PLD: begin
          w_acc_nxt       = r_acc ^ fifo_data;
          w_remaining_nxt = r_remaining - 6'd1;
          if (r_remaining == 6'd1) begin
            w_state_nxt = ST_PAR;
          end
        end
        ST_PAR: begin
          w_in_eop    = 1'b1;
          w_done      = 1'b1;
          w_perr      = (fifo_data != r_acc);
          w_state_nxt = ST_HDR;
        end
        default: w_state_nxt = ST_HDR;
      endcase
    end
    if (w_timeout) begin
      w_state_nxt = ST_HDR;
    end
  end

  // Two-entry buffer update. The order is:
  //   1. pop,
  //   2. push the captured byte,
  //   3. on abort, tag the newest entry as eop, or insert a 0x00 eop beat if nothing is left.
  always_comb begin
    w_buf_nxt[0] = r_buf[0];
    w_buf_nxt[1] = r_buf[1];
    w_occ_nxt    = r_occ;
    if (w_pop) begin
      w_buf_nxt[0] = r_buf[1];
      w_occ_nxt    = r_occ - 2'd1;
    end
    if (w_capture) begin
      w_buf_nxt[w_occ_nxt[0]] = {w_in_sop, w_in_eop, fifo_data};
      w_occ_nxt               = w_occ_nxt + 2'd1;
    end
    if (w_timeout) begin
      if (w_occ_nxt == 2'd0) begin
        w_buf_nxt[0] = {1'b0, 1'b1, 8'h00};
        w_occ_nxt    = 2'd1;
      end else begin
        w_buf_nxt[w_occ_nxt[1]][8] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_buf[0]     <= '0;
      r_buf[1]     <= '0;
      r_occ        <= '0;
      r_rd_pend    <= 1'b0;
      r_run        <= 1'b0;
      r_remaining  <= '0;
      r_acc        <= '0;
      r_pkt_done   <= 1'b0;
      r_parity_err <= 1'b0;
      r_pkt_count  <= '0;
      r_err_count  <= '0;
    end else begin
      r_buf[0]     <= w_buf_nxt[0];
      r_buf[1]     <= w_buf_nxt[1];
      r_occ        <= w_occ_nxt;
      r_rd_pend    <= read_enb;
      r_run        <= 1'b1;
      r_remaining  <= w_remaining_nxt;
      r_acc        <= w_acc_nxt;
      r_pkt_done   <= w_done;
      r_parity_err <= w_perr;
      if (w_done) begin
        r_pkt_count <= r_pkt_count + CNT_W'(1);
      end
      if ((w_perr || w_timeout) && (r_err_count != 8'hFF)) begin
        r_err_count <= r_err_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_router_pkt_reader.sv
`timescale 1ns/1ps
module tb_router_pkt_reader;
  localparam int unsigned TO = 30;
  localparam int unsigned CW = 16;

  logic          clock      = 1'b0;
  logic          resetn     = 1'b0;
  logic          empty;
  logic [7:0]    fifo_data  = 8'h00;
  logic          read_enb;
  logic [7:0]    m_data;
  logic          m_valid;
  logic          m_ready    = 1'b0;
  logic          m_sop, m_eop, pkt_done, parity_err, pkt_abort, busy;
  logic [CW-1:0] pkt_count;
  logic [7:0]    err_count;

  always #5 clock = ~clock;

  router_pkt_reader #(.TIMEOUT_CYC(TO), .CNT_W(CW)) dut (
    .clock(clock), .resetn(resetn), .empty(empty), .fifo_data(fifo_data),
    .read_enb(read_enb), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_sop(m_sop), .m_eop(m_eop), .pkt_done(pkt_done), .parity_err(parity_err),
    .pkt_abort(pkt_abort), .pkt_count(pkt_count), .err_count(err_count), .busy(busy)
  );

  int errors = 0;
  int checks = 0;

  // FIFO model: data appears the cycle after the read strobe
  logic [7:0]  fmem [4096];
  int unsigned wr_ptr = 0;
  int unsigned rd_ptr = 0;
  logic        stall  = 1'b0;
  assign empty = stall || (rd_ptr == wr_ptr);
  always @(posedge clock) begin
    if (read_enb) begin
      fifo_data <= fmem[rd_ptr[11:0]];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  // Reference stream model: {sop, eop, data}
  logic [9:0]  exp_q [$];
  logic [7:0]  pl_src [$];
  int unsigned exp_pkts = 0;
  int unsigned exp_err  = 0;

  // Sink monitor
  logic [9:0] obs [$];
  int  n_done, n_perr, n_abort, perr_alone, stab_err, ovf_err;
  int  issued, accepted, starve, abort_starve, cyc, first_rd, first_vld;
  logic hold_prev, tb_pend;
  logic [9:0] hold_val;
  int  bp_mode = 0;
  bit  rnd_stall = 0;

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      issued = 0; accepted = 0; hold_prev = 1'b0; tb_pend = 1'b0; starve = 0;
    end else begin
      cyc++;
      if (read_enb) begin
        if (issued - accepted >= 2) ovf_err++;
        issued++;
        if (first_rd < 0) first_rd = cyc;
      end
      if (m_valid && first_vld < 0) first_vld = cyc;
      if (m_valid && m_ready) begin
        obs.push_back({m_sop, m_eop, m_data});
        accepted++;
      end
      if (hold_prev && (!m_valid || ({m_sop, m_eop, m_data} !== hold_val))) stab_err++;
      hold_prev = m_valid && !m_ready;
      hold_val  = {m_sop, m_eop, m_data};
      if (pkt_done) n_done++;
      if (parity_err) begin
        n_perr++;
        if (!pkt_done) perr_alone++;
      end
      if (!busy || tb_pend) starve = 0;
      else if (empty) starve++;
      if (pkt_abort) begin
        n_abort++;
        abort_starve = starve;
      end
      tb_pend = read_enb;
    end
  end

  initial begin
    #900us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic clear_stats();
    obs.delete(); exp_q.delete();
    n_done = 0; n_perr = 0; n_abort = 0; perr_alone = 0; stab_err = 0; ovf_err = 0;
    issued = 0; accepted = 0; abort_starve = -1; first_rd = -1; first_vld = -1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    fmem[wr_ptr[11:0]] = b;
    wr_ptr++;
  endtask

  // Whole packet: payload from pl_src if available, else random; parity is XOR of header and payload
  task automatic push_pkt(input logic [7:0] hdr, input logic [7:0] par_flip);
    logic [7:0]  par;
    logic [7:0]  b;
    int unsigned len;
    par = hdr;
    len = int'(hdr[7:2]);
    push_byte(hdr);
    exp_q.push_back({2'b10, hdr});
    for (int unsigned i = 0; i < len; i++) begin
      if (pl_src.size() > 0) b = pl_src.pop_front();
      else b = 8'($urandom);
      par ^= b;
      push_byte(b);
      exp_q.push_back({2'b00, b});
    end
    par ^= par_flip;
    push_byte(par);
    exp_q.push_back({2'b01, par});
    exp_pkts++;
    if (par_flip != 8'h00 && exp_err < 255) exp_err++;
  endtask

  task automatic wait_beats(input int unsigned n, input int unsigned budget, output bit ok);
    ok = 1'b0;
    for (int unsigned c = 0; c < budget; c++) begin
      @(negedge clock);
      case (bp_mode)
        1:       m_ready = !m_ready;
        2:       m_ready = 1'($urandom_range(1, 0));
        default: m_ready = 1'b1;
      endcase
      stall = rnd_stall ? ($urandom_range(3, 0) == 0) : 1'b0;
      if (obs.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
    m_ready = 1'b1; stall = 1'b0; bp_mode = 0; rnd_stall = 0;
    repeat (4) @(negedge clock);
  endtask

  task automatic test_reset();
    resetn = 1'b0; m_ready = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if ({read_enb, m_valid, m_sop, m_eop, pkt_done, parity_err, pkt_abort, busy} !== 8'h00) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 00000000",
               {read_enb, m_valid, m_sop, m_eop, pkt_done, parity_err, pkt_abort, busy});
    end
    checks++;
    if (m_data !== 8'h00) begin
      errors++; $display("FAIL reset_m_data: got %h expected 00", m_data);
    end
    checks++;
    if (pkt_count !== '0) begin
      errors++; $display("FAIL reset_pkt_count: got %0d expected 0", pkt_count);
    end
    checks++;
    if (err_count !== 8'd0) begin
      errors++; $display("FAIL reset_err_count: got %0d expected 0", err_count);
    end
    resetn = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if ({m_valid, read_enb, busy} !== 3'b000) begin
      errors++; $display("FAIL idle_after_reset: got %b expected 000", {m_valid, read_enb, busy});
    end
  endtask

  task automatic test_basic();
    bit ok;
    clear_stats();
    pl_src.push_back(8'h11); pl_src.push_back(8'h22); pl_src.push_back(8'h33);
    push_pkt(8'h0C, 8'h00);
    wait_beats(exp_q.size(), 200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_wait: got %0d beats expected %0d", obs.size(), exp_q.size()); end
    checks++;
    if (obs.size() != exp_q.size()) begin errors++; $display("FAIL basic_len: got %0d expected %0d", obs.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      checks++;
      if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL basic_beat%0d: got %h expected %h", i, obs[i], exp_q[i]); end
    end
    checks++;
    if (n_done != 1 || n_perr != 0) begin errors++; $display("FAIL basic_pulses: got done=%0d perr=%0d expected 1/0", n_done, n_perr); end
    checks++;
    if (pkt_count !== CW'(exp_pkts) || err_count !== 8'(exp_err)) begin
      errors++; $display("FAIL basic_counts: got %0d/%0d expected %0d/%0d", pkt_count, err_count, exp_pkts, exp_err);
    end
    checks++;
    if (first_vld - first_rd != 2) begin errors++; $display("FAIL basic_latency: got %0d expected 2", first_vld - first_rd); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b expected 0", busy); end
  endtask

  task automatic test_parity_err();
    bit ok;
    clear_stats();
    pl_src.push_back(8'h11); pl_src.push_back(8'h22); pl_src.push_back(8'h33);
    push_pkt(8'h0C, 8'h01);
    push_pkt(8'($urandom), 8'h00);
    wait_beats(exp_q.size(), 400, ok);
    checks++;
    if (!ok || obs.size() != exp_q.size()) begin errors++; $display("FAIL perr_len: got %0d expected %0d", obs.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      checks++;
      if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL perr_beat%0d: got %h expected %h", i, obs[i], exp_q[i]); end
    end
    checks++;
    if (n_done != 2 || n_perr != 1 || perr_alone != 0) begin
      errors++; $display("FAIL perr_pulses: got done=%0d perr=%0d alone=%0d expected 2/1/0", n_done, n_perr, perr_alone);
    end
    checks++;
    if (pkt_count !== CW'(exp_pkts) || err_count !== 8'(exp_err)) begin
      errors++; $display("FAIL perr_counts: got %0d/%0d expected %0d/%0d", pkt_count, err_count, exp_pkts, exp_err);
    end
  endtask

  task automatic test_zero_len();
    bit ok;
    clear_stats();
    push_pkt(8'h00, 8'h00);
    wait_beats(2, 100, ok);
    checks++;
    if (!ok || obs.size() != 2) begin errors++; $display("FAIL zlen_len: got %0d expected 2", obs.size()); end
    for (int i = 0; i < 2 && i < obs.size(); i++) begin
      checks++;
      if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL zlen_beat%0d: got %h expected %h", i, obs[i], exp_q[i]); end
    end
    checks++;
    if (n_done != 1 || n_perr != 0 || err_count !== 8'(exp_err)) begin
      errors++; $display("FAIL zlen_pulses: got done=%0d perr=%0d err=%0d expected 1/0/%0d", n_done, n_perr, err_count, exp_err);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    clear_stats();
    push_pkt({6'd63, 2'($urandom)}, 8'h00);
    bp_mode = 1;
    wait_beats(exp_q.size(), 2000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp63_wait: got %0d expected %0d", obs.size(), exp_q.size()); end
    for (int p = 0; p < 6; p++) begin
      push_pkt(8'($urandom), ($urandom_range(2, 0) == 0) ? 8'(1 << $urandom_range(7, 0)) : 8'h00);
    end
    bp_mode = 2; rnd_stall = 1;
    wait_beats(exp_q.size(), 4000, ok);
    checks++;
    if (!ok || obs.size() != exp_q.size()) begin errors++; $display("FAIL bp_len: got %0d expected %0d", obs.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      checks++;
      if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL bp_beat%0d: got %h expected %h", i, obs[i], exp_q[i]); end
    end
    checks++;
    if (ovf_err != 0 || stab_err != 0) begin errors++; $display("FAIL bp_flow: got ovf=%0d stab=%0d expected 0/0", ovf_err, stab_err); end
    checks++;
    if (n_done != 7 || pkt_count !== CW'(exp_pkts) || err_count !== 8'(exp_err)) begin
      errors++; $display("FAIL bp_counts: got done=%0d %0d/%0d expected 7 %0d/%0d", n_done, pkt_count, err_count, exp_pkts, exp_err);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_stats();
    m_ready = 1'b0;
    push_pkt({6'd10, 2'b01}, 8'h00);
    repeat (8) @(negedge clock);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy: got %b expected 1", busy); end
    resetn = 1'b0;
    #1;
    checks++;
    if ({read_enb, m_valid, m_sop, m_eop, pkt_done, parity_err, pkt_abort, busy} !== 8'h00 ||
        m_data !== 8'h00 || pkt_count !== '0 || err_count !== 8'd0) begin
      errors++; $display("FAIL rmid_reset: got %b %h %0d %0d expected zeros",
        {read_enb, m_valid, m_sop, m_eop, pkt_done, parity_err, pkt_abort, busy}, m_data, pkt_count, err_count);
    end
    @(negedge clock);
    wr_ptr = rd_ptr;
    exp_pkts = 0; exp_err = 0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    checks++;
    if (n_done + n_perr + n_abort != 0) begin errors++; $display("FAIL rmid_pulses: got %0d expected 0", n_done + n_perr + n_abort); end
    clear_stats();
    push_pkt(8'($urandom), 8'h00);
    wait_beats(exp_q.size(), 300, ok);
    checks++;
    if (!ok || obs.size() != exp_q.size()) begin errors++; $display("FAIL rmid_len: got %0d expected %0d", obs.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      checks++;
      if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL rmid_beat%0d: got %h expected %h", i, obs[i], exp_q[i]); end
    end
    checks++;
    if (n_done != 1 || pkt_count !== CW'(1)) begin errors++; $display("FAIL rmid_count: got %0d/%0d expected 1/1", n_done, pkt_count); end
  endtask

`ifdef ROUTER_RD_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    logic [7:0] p1, p2;
    clear_stats();
    p1 = 8'($urandom); p2 = 8'($urandom);
    push_byte(8'h14); push_byte(p1); push_byte(p2);
    exp_q.push_back({2'b10, 8'h14}); exp_q.push_back({2'b00, p1});
    exp_q.push_back({2'b00, p2});    exp_q.push_back({2'b01, 8'h00});
    if (exp_err < 255) exp_err++;
    wait_beats(4, 200, ok);
    checks++;
    if (!ok || obs.size() != 4) begin errors++; $display("FAIL to1_len: got %0d expected 4", obs.size()); end
    for (int i = 0; i < 4 && i < obs.size(); i++) begin
      checks++;
      if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL to1_beat%0d: got %h expected %h", i, obs[i], exp_q[i]); end
    end
    checks++;
    if (n_abort != 1 || abort_starve != int'(TO) || n_done != 0) begin
      errors++; $display("FAIL to1_abort: got n=%0d at=%0d done=%0d expected 1/%0d/0", n_abort, abort_starve, n_done, TO);
    end
    checks++;
    if (err_count !== 8'(exp_err) || busy !== 1'b0) begin
      errors++; $display("FAIL to1_state: got err=%0d busy=%b expected %0d/0", err_count, busy, exp_err);
    end

    // Abort while the sink is stalled: the newest buffered byte carries eop
    clear_stats();
    m_ready = 1'b0;
    p1 = 8'($urandom);
    push_byte(8'h14); push_byte(p1);
    exp_q.push_back({2'b10, 8'h14}); exp_q.push_back({2'b01, p1});
    if (exp_err < 255) exp_err++;
    repeat (45) @(negedge clock);
    wait_beats(2, 100, ok);
    checks++;
    if (!ok || obs.size() != 2) begin errors++; $display("FAIL to2_len: got %0d expected 2", obs.size()); end
    for (int i = 0; i < 2 && i < obs.size(); i++) begin
      checks++;
      if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL to2_beat%0d: got %h expected %h", i, obs[i], exp_q[i]); end
    end
    checks++;
    if (n_abort != 1 || abort_starve != int'(TO) || err_count !== 8'(exp_err)) begin
      errors++; $display("FAIL to2_abort: got n=%0d at=%0d err=%0d expected 1/%0d/%0d", n_abort, abort_starve, err_count, TO, exp_err);
    end

    clear_stats();
    push_pkt(8'($urandom), 8'h00);
    wait_beats(exp_q.size(), 300, ok);
    checks++;
    if (!ok || obs.size() != exp_q.size()) begin errors++; $display("FAIL to3_len: got %0d expected %0d", obs.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      checks++;
      if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL to3_beat%0d: got %h expected %h", i, obs[i], exp_q[i]); end
    end
    checks++;
    if (n_done != 1 || pkt_count !== CW'(exp_pkts)) begin errors++; $display("FAIL to3_count: got %0d/%0d expected 1/%0d", n_done, pkt_count, exp_pkts); end
  endtask
`else
  task automatic test_no_timeout();
    bit ok;
    logic [7:0] b [5];
    logic [7:0] par;
    clear_stats();
    par = 8'h14;
    push_byte(8'h14);
    exp_q.push_back({2'b10, 8'h14});
    for (int i = 0; i < 5; i++) begin
      b[i] = 8'($urandom);
      par ^= b[i];
      exp_q.push_back({2'b00, b[i]});
    end
    exp_q.push_back({2'b01, par});
    exp_pkts++;
    push_byte(b[0]); push_byte(b[1]);
    repeat (60) @(negedge clock);
    checks++;
    if (n_abort != 0 || busy !== 1'b1 || obs.size() != 3) begin
      errors++; $display("FAIL nto_wait: got abort=%0d busy=%b beats=%0d expected 0/1/3", n_abort, busy, obs.size());
    end
    push_byte(b[2]); push_byte(b[3]); push_byte(b[4]); push_byte(par);
    wait_beats(exp_q.size(), 200, ok);
    checks++;
    if (!ok || obs.size() != exp_q.size()) begin errors++; $display("FAIL nto_len: got %0d expected %0d", obs.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      checks++;
      if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL nto_beat%0d: got %h expected %h", i, obs[i], exp_q[i]); end
    end
    checks++;
    if (n_done != 1 || n_perr != 0 || err_count !== 8'(exp_err)) begin
      errors++; $display("FAIL nto_pulses: got done=%0d perr=%0d err=%0d expected 1/0/%0d", n_done, n_perr, err_count, exp_err);
    end
  endtask
`endif

  initial begin
    cyc = 0;
    clear_stats();
    test_reset();
    test_basic();
    test_parity_err();
    test_zero_len();
    test_backpressure();
    test_reset_mid();
`ifdef ROUTER_RD_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
